// File: rtl/deg_pkg.sv
// Shared types for the countdown timer: FSM states, BCD limits,
// the MM:SS digit bundle and the BCD borrow-chain decrement.
package deg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] SEC_T_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
  } time_t;

  // One-second BCD decrement. Caller guarantees t != 00:00,
  // so min_t never wraps.
  function automatic time_t bcd_dec(input time_t t);
    time_t r;
    r = t;
    if (t.sec_u != 4'd0) begin
      r.sec_u = t.sec_u - 4'd1;
    end else begin
      r.sec_u = DIGIT_MAX;
      if (t.sec_t != 4'd0) begin
        r.sec_t = t.sec_t - 4'd1;
      end else begin
        r.sec_t = SEC_T_MAX;
        if (t.min_u != 4'd0) begin
          r.min_u = t.min_u - 4'd1;
        end else begin
          r.min_u = DIGIT_MAX;
          r.min_t = t.min_t - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser for an asynchronous level plus a registered rising-edge pulse.
// Ports: clk, rst_n, din (async level), pulse (1-cycle, STAGES+1 edges after rise).
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] chain;
  logic              sync_out;
  logic              sync_prev;

  assign sync_out = chain[STAGES-1];

  // The pulse itself is registered so downstream logic sees a clean
  // flop output; this adds the one edge beyond the synchroniser depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain     <= '0;
      sync_prev <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      chain     <= {chain[STAGES-2:0], din};
      sync_prev <= sync_out;
      pulse     <= sync_out & ~sync_prev;
    end
  end

endmodule

// File: rtl/deg_tick_timer.sv
// MM:SS BCD countdown timer paced by rising edges of the divided d_clk.
// Ports: clk, rst_n, d_clk, load/ld_*, start, pause, clear -> digits, running, expired, done, load_err.
module deg_tick_timer
  import deg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_T_MAX   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_clk,
  input  logic       load,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_u,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_u,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       load_err
);

  localparam logic [3:0] MIN_T_LIM = 4'(MIN_T_MAX);

  logic   tick;
  state_e state_q, state_d;
  time_t  cur_q, cur_d;
  time_t  ld_v;
  logic   ld_ok;
  logic   is_zero;
  logic   done_d, err_d;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (d_clk),
    .pulse(tick)
  );

  assign ld_v    = {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u};
  assign ld_ok   = (ld_min_t <= MIN_T_LIM)
                && (ld_min_u <= DIGIT_MAX)
                && (ld_sec_t <= SEC_T_MAX)
                && (ld_sec_u <= DIGIT_MAX);
  assign is_zero = (cur_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      done     <= done_d;
      load_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cur_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            if (ld_ok) cur_d = ld_v;
            else       err_d = 1'b1;
          end else if (start && !is_zero) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // A tick coinciding with pause is still consumed.
          if (tick) begin
            if (is_zero) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end else begin
              cur_d = bcd_dec(cur_q);
            end
          end
          if (pause && state_d == RUN) state_d = PAUSED;
        end
        PAUSED: begin
          if (start && !pause) state_d = RUN;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign min_t   = cur_q.min_t;
  assign min_u   = cur_q.min_u;
  assign sec_t   = cur_q.sec_t;
  assign sec_u   = cur_q.sec_u;
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);

endmodule

// File: tb/tb_deg_tick_timer.sv
// Directed self-checking bench for deg_tick_timer.
// Drives d_clk periods and control pulses, compares digits/flags to constants.
module tb_deg_tick_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_clk;
  logic       load;
  logic [3:0] ld_min_t, ld_min_u, ld_sec_t, ld_sec_u;
  logic       start, pause, clear;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       running, expired, done, load_err;
  logic [15:0] dig;

  int checks = 0;
  int errs   = 0;
  int dc;

  assign dig = {min_t, min_u, sec_t, sec_u};

  always #5 clk = ~clk;

  deg_tick_timer #(
    .SYNC_STAGES(2),
    .MIN_T_MAX  (9)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_clk   (d_clk),
    .load    (load),
    .ld_min_t(ld_min_t),
    .ld_min_u(ld_min_u),
    .ld_sec_t(ld_sec_t),
    .ld_sec_u(ld_sec_u),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .min_t   (min_t),
    .min_u   (min_u),
    .sec_t   (sec_t),
    .sec_u   (sec_u),
    .running (running),
    .expired (expired),
    .done    (done),
    .load_err(load_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [15:0] v);
    {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic per(output int n);
    n = 0;
    d_clk = 1'b1;
    repeat (8) begin
      step();
      n += int'(done);
    end
    d_clk = 1'b0;
    repeat (8) begin
      step();
      n += int'(done);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d_clk = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = 16'h0;
    repeat (3) step();
    chk("rst_dig", dig, 16'h0000);
    chk("rst_flags", {running, expired, done, load_err}, 4'b0000);
    rst_n = 1'b1;
    step();

    // 00:03 down to expiry
    ld(16'h0003);
    go();
    chk("t1_run", running, 1'b1);
    per(dc);
    chk("t1_p1", dig, 16'h0002);
    per(dc);
    chk("t1_p2", dig, 16'h0001);
    per(dc);
    chk("t1_p3", dig, 16'h0000);
    chk("t1_p3_done", dc, 0);
    chk("t1_p3_run", running, 1'b1);
    per(dc);
    chk("t1_done_cnt", dc, 1);
    chk("t1_exp", {running, expired}, 2'b01);
    chk("t1_p4", dig, 16'h0000);
    go();
    chk("t1_exp_start", {running, expired}, 2'b01);
    clr();
    chk("t1_clr", {running, expired}, 2'b00);

    // 10:00 -> 09:59 with tick latency
    ld(16'h1000);
    go();
    d_clk = 1'b1;
    step();
    chk("t2_tick_e1", dut.tick, 1'b0);
    step();
    chk("t2_tick_e2", dut.tick, 1'b0);
    step();
    chk("t2_tick_e3", dut.tick, 1'b1);
    chk("t2_dig_e3", dig, 16'h1000);
    step();
    chk("t2_dig_e4", dig, 16'h0959);
    chk("t2_tick_e4", dut.tick, 1'b0);
    repeat (4) step();
    d_clk = 1'b0;
    repeat (8) step();
    chk("t2_fall", dig, 16'h0959);
    clr();

    // pause / resume at 05:30
    ld(16'h0530);
    go();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("t3_paused", running, 1'b0);
    repeat (5) per(dc);
    chk("t3_hold", dig, 16'h0530);
    go();
    per(dc);
    chk("t3_resume", dig, 16'h0529);
    chk("t3_run", running, 1'b1);
    clr();

    // illegal and out-of-state loads
    ld(16'h0075);
    chk("t4_err", load_err, 1'b1);
    chk("t4_dig", dig, 16'h0000);
    step();
    chk("t4_err_pulse", load_err, 1'b0);
    ld(16'hA000);
    chk("t4_err_mt", load_err, 1'b1);
    ld(16'h0030);
    chk("t4_ok", {dig, load_err}, {16'h0030, 1'b0});
    go();
    ld(16'h0300);
    chk("t4_run_ld", dig, 16'h0030);
    chk("t4_run_ld_r", running, 1'b1);
    clr();

    // clear collides with tick at 02:00
    ld(16'h0200);
    go();
    d_clk = 1'b1;
    repeat (3) step();
    chk("t5_tick", dut.tick, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t5_dig", dig, 16'h0000);
    chk("t5_idle", running, 1'b0);
    repeat (4) step();
    d_clk = 1'b0;
    repeat (8) step();
    go();
    chk("t5_zero_start", running, 1'b0);

    // pause with tick still decrements
    ld(16'h0010);
    go();
    d_clk = 1'b1;
    repeat (3) step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("t5b_dig", dig, 16'h0009);
    chk("t5b_paused", running, 1'b0);
    repeat (4) step();
    d_clk = 1'b0;
    repeat (8) step();
    clr();

    // async reset mid-RUN
    ld(16'h0100);
    go();
    d_clk = 1'b1;
    step();
    chk("t6_pre", {dig, running}, {16'h0100, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_dig", dig, 16'h0000);
    chk("t6_async_run", running, 1'b0);
    repeat (2) step();
    #2;
    rst_n = 1'b1;
    repeat (10) step();
    chk("t6_rel", {dig, running, expired, done}, {16'h0000, 3'b000});
    d_clk = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
